// File: rtl/tenbaset_frame_tx.sv
// 10BASE-T frame transmitter: preamble/SFD, MAC header, streamed payload, zero pad, FCS,
// TP_IDL and inter-frame gap, Manchester coded onto a differential pair; link pulses while idle.
module tenbaset_frame_tx #(
   parameter logic [47:0] DST_MAC     = 48'hBCAEC5A0F896,
   parameter logic [47:0] SRC_MAC     = 48'h16FD2204B161,
   parameter logic [15:0] ETHERTYPE   = 16'h0800,
   parameter int          MAX_PAYLOAD = 1500,
   parameter int          NLP_PERIOD  = 131072,
   parameter int          IFG_CYCLES  = 192
) (
   input  logic        clkTx,
   input  logic        reset,
   input  logic        start,
   input  logic [10:0] len,
   input  logic [7:0]  din,
   output logic        din_rd,
   output logic        busy,
   output logic        done,
   output logic        Ethernet_TDp,
   output logic        Ethernet_TDm
);

   localparam int               NLP_W    = $clog2(NLP_PERIOD);
   localparam logic [NLP_W-1:0] NLP_LAST = NLP_W'(NLP_PERIOD - 1);
   localparam logic [10:0]      MAX_L    = 11'(MAX_PAYLOAD);
   localparam logic [10:0]      MIN_BODY = 11'd46;
   localparam logic [15:0]      IFG_LAST = 16'(IFG_CYCLES - 1);
   localparam logic [111:0]     HDR      = {DST_MAC, SRC_MAC, ETHERTYPE};

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_PRE, S_HDR, S_PAY, S_PAD, S_FCS, S_TPIDL, S_IFG
   } state_t;

   state_t           r_state;
   logic [3:0]       r_cyc;
   logic [10:0]      r_bidx;
   logic [15:0]      r_cnt;
   logic [NLP_W-1:0] r_nlp;
   logic             r_nlp_hold;
   logic [10:0]      r_len;
   logic [10:0]      r_body;
   logic [10:0]      r_last;
   logic [7:0]       r_sh;
   logic [31:0]      r_crc;

   logic [10:0] w_nb;
   logic [10:0] w_len_c;
   logic [10:0] w_body_c;
   logic [10:0] w_pay_end;
   logic [10:0] w_pad_end;
   logic        w_in_frame;
   logic        w_slot_end;
   logic        w_nb_pay;
   logic        w_bit;
   logic        w_qo;
   state_t      w_region;
   logic [7:0]  w_next_byte;

   function automatic logic [7:0] hdr_byte(input logic [3:0] k);
      int base;
      if (k > 4'd13) return 8'h00;
      base = (13 - int'(k)) * 8;
      return HDR[base +: 8];
   endfunction

   // Serial CRC-32 step, data fed in transmit order (LSB of each byte first).
   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
      return {c[30:0], 1'b0} ^ ((c[31] ^ b) ? 32'h04C11DB7 : 32'h0000_0000);
   endfunction

   always_comb begin
      w_nb       = r_bidx + 11'd1;
      w_len_c    = (len > MAX_L) ? MAX_L : len;
      w_body_c   = (w_len_c < MIN_BODY) ? MIN_BODY : w_len_c;
      w_pay_end  = 11'd22 + r_len;
      w_pad_end  = 11'd22 + r_body;
      w_in_frame = (r_state == S_PRE) || (r_state == S_HDR) || (r_state == S_PAY) ||
                   (r_state == S_PAD) || (r_state == S_FCS);
      w_slot_end = (r_cyc == 4'd15);
      w_nb_pay   = (w_nb >= 11'd22) && (w_nb < w_pay_end);
      w_bit      = (r_state == S_FCS) ? ~r_crc[31] : r_sh[r_cyc[3:1]];
      w_qo       = r_cyc[0] ? w_bit : ~w_bit;

      w_region    = S_FCS;
      w_next_byte = 8'h00;
      if (w_nb < 11'd8) begin
         w_region    = S_PRE;
         w_next_byte = (w_nb == 11'd7) ? 8'hD5 : 8'h55;
      end else if (w_nb < 11'd22) begin
         w_region    = S_HDR;
         w_next_byte = hdr_byte(4'(w_nb - 11'd8));
      end else if (w_nb < w_pay_end) begin
         w_region    = S_PAY;
         w_next_byte = din;
      end else if (w_nb < w_pad_end) begin
         w_region    = S_PAD;
      end
   end

   // Control FSM with registered pins and strobes.
   always_ff @(posedge clkTx or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_cyc        <= 4'd0;
         r_bidx       <= 11'd0;
         r_cnt        <= 16'd0;
         r_nlp        <= '0;
         r_nlp_hold   <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         din_rd       <= 1'b0;
         Ethernet_TDp <= 1'b0;
         Ethernet_TDm <= 1'b0;
      end else begin
         done   <= 1'b0;
         din_rd <= 1'b0;
         if (r_state != S_IDLE) r_nlp <= '0;
         case (r_state)
            S_IDLE: begin
               Ethernet_TDp <= 1'b0;
               Ethernet_TDm <= 1'b0;
               r_nlp_hold   <= 1'b0;
               if (start) begin
                  r_state <= S_START;
                  busy    <= 1'b1;
                  r_nlp   <= '0;
               end else if (r_nlp == NLP_LAST) begin
                  r_nlp        <= '0;
                  r_nlp_hold   <= 1'b1;
                  Ethernet_TDp <= 1'b1;
               end else begin
                  r_nlp <= r_nlp + NLP_W'(1);
                  if (r_nlp_hold) Ethernet_TDp <= 1'b1;
               end
            end
            S_START: begin
               Ethernet_TDp <= 1'b0;
               Ethernet_TDm <= 1'b0;
               r_state      <= S_PRE;
               r_cyc        <= 4'd0;
               r_bidx       <= 11'd0;
            end
            S_PRE, S_HDR, S_PAY, S_PAD, S_FCS: begin
               Ethernet_TDp <= w_qo;
               Ethernet_TDm <= ~w_qo;
               r_cyc        <= r_cyc + 4'd1;
               if ((r_cyc == 4'd14) && w_nb_pay) din_rd <= 1'b1;
               if (w_slot_end) begin
                  if (r_bidx == r_last) begin
                     r_state <= S_TPIDL;
                     r_cnt   <= 16'd0;
                  end else begin
                     r_state <= w_region;
                     r_bidx  <= w_nb;
                  end
               end
            end
            S_TPIDL: begin
               Ethernet_TDp <= 1'b1;
               Ethernet_TDm <= 1'b0;
               if (r_cnt == 16'd5) begin
                  r_state <= S_IFG;
                  r_cnt   <= 16'd0;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_IFG: begin
               Ethernet_TDp <= 1'b0;
               Ethernet_TDm <= 1'b0;
               if (r_cnt == IFG_LAST) begin
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Datapath: frame geometry, byte shifter and CRC; the FCS is shifted straight out of r_crc.
   always_ff @(posedge clkTx) begin
      if ((r_state == S_IDLE) && start) begin
         r_len  <= w_len_c;
         r_body <= w_body_c;
         r_last <= w_body_c + 11'd25;
      end
      if (r_state == S_START) begin
         r_sh <= 8'h55;
      end else if (w_in_frame && w_slot_end) begin
         r_sh <= w_next_byte;
      end
      if (r_state == S_PRE) begin
         r_crc <= 32'hFFFF_FFFF;
      end else if (((r_state == S_HDR) || (r_state == S_PAY) || (r_state == S_PAD)) && r_cyc[0]) begin
         r_crc <= crc_step(r_crc, w_bit);
      end else if ((r_state == S_FCS) && r_cyc[0]) begin
         r_crc <= {r_crc[30:0], 1'b0};
      end
   end

endmodule
